// File: rtl/draw_if.sv
// draw_if: start/done handshake between the frame scheduler and the shared entity drawer
// master drives draw_start, draw_entity, draw_erase, draw_idx; slave returns draw_done
interface draw_if #(
  parameter int ENTITY_SIZE = 34,
  parameter int IDX_W = 3
);
  logic draw_start;
  logic [ENTITY_SIZE-1:0] draw_entity;
  logic draw_erase;
  logic [IDX_W-1:0] draw_idx;
  logic draw_done;
  modport master(output draw_start, draw_entity, draw_erase, draw_idx, input draw_done);
  modport slave(input draw_start, draw_entity, draw_erase, draw_idx, output draw_done);
endinterface

// File: rtl/frame_scheduler.sv
// frame_scheduler: per frame, erase the previous image of each valid entity then draw the current one
// clk/reset_n: clock and async active-low reset; frame_tick: frame pulse; entities_in: flattened entity words
// draw: handshake to the shared drawer; busy/frame_done/overrun/timeout: status and one-cycle event pulses
module frame_scheduler #(
  parameter int NUM_ENTITIES = 8,
  parameter int ENTITY_SIZE = 34,
  parameter int IDX_W = 3,
  parameter int TIMEOUT = 4096
)(
  input  logic clk,
  input  logic reset_n,
  input  logic frame_tick,
  input  logic [NUM_ENTITIES*ENTITY_SIZE-1:0] entities_in,
  draw_if.master draw,
  output logic busy,
  output logic frame_done,
  output logic overrun,
  output logic timeout
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [2:0] {IDLE, SCAN, ISSUE, WAIT, FINISH} state_t;
  state_t state, state_nx;
  logic [ENTITY_SIZE-1:0] cur [NUM_ENTITIES];
  logic [ENTITY_SIZE-1:0] prev [NUM_ENTITIES];
  logic [IDX_W-1:0] idx;
  logic erase_phase;
  logic [CW-1:0] cnt;
  logic [ENTITY_SIZE-1:0] word;
  logic last, advance, valid, done_frame;
  always_comb begin
    word = erase_phase ? prev[idx] : cur[idx];
    valid = word[ENTITY_SIZE-1];
    last = idx == IDX_W'(NUM_ENTITIES-1);
    busy = state != IDLE;
    frame_done = state == FINISH;
    overrun = frame_tick && busy;
    draw.draw_start = state == ISSUE;
    // a done in the same cycle as expiry counts as a normal completion
    timeout = state == WAIT && !draw.draw_done && cnt == CW'(TIMEOUT-1);
    advance = (state == SCAN && !valid) || (state == WAIT && (draw.draw_done || timeout));
    done_frame = last && !erase_phase;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = frame_tick ? SCAN : IDLE;
      SCAN:    state_nx = valid ? ISSUE : done_frame ? FINISH : SCAN;
      ISSUE:   state_nx = WAIT;
      WAIT:    state_nx = advance ? (done_frame ? FINISH : SCAN) : WAIT;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < NUM_ENTITIES; i++) begin
        cur[i] <= '0;
        prev[i] <= '0;
      end
      idx <= '0;
      erase_phase <= 1'b0;
      cnt <= '0;
      draw.draw_entity <= '0;
      draw.draw_erase <= 1'b0;
      draw.draw_idx <= '0;
    end else begin
      if (state == IDLE && frame_tick) begin
        for (int i = 0; i < NUM_ENTITIES; i++) cur[i] <= entities_in[i*ENTITY_SIZE +: ENTITY_SIZE];
        idx <= '0;
        erase_phase <= 1'b1;
      end
      if (advance) begin
        idx <= last ? '0 : idx + 1'b1;
        if (last) erase_phase <= 1'b0;
      end
      if (state == SCAN && valid) begin
        draw.draw_entity <= word;
        draw.draw_erase <= erase_phase;
        draw.draw_idx <= idx;
      end
      cnt <= state == ISSUE ? '0 : (state == WAIT && cnt != CW'(TIMEOUT-1)) ? cnt + 1'b1 : cnt;
      if (state == FINISH) begin
        prev <= cur;
        draw.draw_entity <= '0;
        draw.draw_erase <= 1'b0;
        draw.draw_idx <= '0;
      end
    end
endmodule
